// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS opcode/funct constants, field positions and issuer state enum
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SW     = 6'd43;
  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } issue_state_e;

  // Only add, sub, lw and sw are executed by the downstream CPU.
  function automatic logic is_supported(input logic [31:0] word);
    logic [5:0] op;
    logic [5:0] funct;
    op    = word[OP_MSB:OP_LSB];
    funct = word[FUNCT_MSB:FUNCT_LSB];
    return ((op == OP_RTYPE) && ((funct == FUNCT_ADD) || (funct == FUNCT_SUB))) ||
           (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous instruction queue with occupancy-based full/empty
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_issuer.sv
// rtl/instr_issuer.sv - paced MIPS instruction issue stage; INSTR_ISSUER_OPCHECK_EN discards unsupported words
module instr_issuer #(
  parameter int DEPTH = 8,
  parameter int GAP   = 6,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  output logic             full,
  output logic             empty,
  input  logic             run,
  output logic [31:0]      instrword,
  output logic             newinstr,
  output logic             busy,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             illegal
);

  import mips_isa_pkg::*;

  localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 2);

  issue_state_e     state_q, state_d;
  logic [31:0]      instrword_q, instrword_d;
  logic             newinstr_q, newinstr_d;
  logic             busy_q, busy_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             pop;
  logic [31:0]      head;
  logic             head_ok;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

`ifdef INSTR_ISSUER_OPCHECK_EN
  assign head_ok = is_supported(head);
`else
  assign head_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    instrword_d  = instrword_q;
    newinstr_d   = 1'b0;
    illegal_d    = 1'b0;
    issued_cnt_d = issued_cnt_q;
    gap_d        = gap_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run && !empty) begin
          pop = 1'b1;
          if (head_ok) begin
            instrword_d = head;
            newinstr_d  = 1'b1;
            state_d     = ST_ISSUE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        issued_cnt_d = issued_cnt_q + 1'b1;
        gap_d        = GAP_LOAD;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // An unsupported head falls back to IDLE, where it is discarded.
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (run && !empty && head_ok) begin
          pop         = 1'b1;
          instrword_d = head;
          newinstr_d  = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      instrword_q  <= '0;
      newinstr_q   <= 1'b0;
      busy_q       <= 1'b0;
      illegal_q    <= 1'b0;
      issued_cnt_q <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      instrword_q  <= instrword_d;
      newinstr_q   <= newinstr_d;
      busy_q       <= busy_d;
      illegal_q    <= illegal_d;
      issued_cnt_q <= issued_cnt_d;
      gap_q        <= gap_d;
    end
  end

  assign instrword  = instrword_q;
  assign newinstr   = newinstr_q;
  assign busy       = busy_q;
  assign illegal    = illegal_q;
  assign issued_cnt = issued_cnt_q;

endmodule
